// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared opcodes, counter encodings and predictor FSM states.
//  Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam logic [4:0] OPC_JAL_5    = 5'b11011;
    localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && (cnt != 2'(ST)))
            res = cnt + 2'd1;
        else if (!taken && (cnt != 2'(SNT)))
            res = cnt - 2'd1;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_pred_if.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_pred_if
//  Brief    : Lookup, training and performance-counter bundle of the predictor.
//  Revision : 1.0
// ============================================================================
interface gshare_pred_if #(
    parameter int IDX_BITS = 8
);
    logic [31:0]         lk_pc;
    logic [31:0]         lk_imm;
    logic [4:0]          lk_opc;
    logic                lk_taken;
    logic [31:0]         lk_target;
    logic [IDX_BITS-1:0] lk_idx;
    logic                up_valid;
    logic [IDX_BITS-1:0] up_idx;
    logic                up_taken;
    logic                up_mispred;
    logic                perf_clear;
    logic                ready;
    logic [31:0]         br_count;
    logic [31:0]         mispred_count;

    modport master (
        output lk_pc, lk_imm, lk_opc, up_valid, up_idx, up_taken, up_mispred, perf_clear,
        input  lk_taken, lk_target, lk_idx, ready, br_count, mispred_count
    );

    modport slave (
        input  lk_pc, lk_imm, lk_opc, up_valid, up_idx, up_taken, up_mispred, perf_clear,
        output lk_taken, lk_target, lk_idx, ready, br_count, mispred_count
    );
endinterface
`default_nettype wire

// File: rtl/pht_ram.sv
`default_nettype none
// ============================================================================
//  Module   : pht_ram
//  Brief    : 2-bit counter table, two async read ports and one sync write.
//  Revision : 1.0
// ============================================================================
module pht_ram #(
    parameter int ENTRIES = 256,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [1:0]    wdata,
    input  wire logic [AW-1:0] raddr_a,
    output logic      [1:0]    rdata_a,
    input  wire logic [AW-1:0] raddr_b,
    output logic      [1:0]    rdata_b
);
    logic [1:0] r_mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we)
            r_mem[waddr] <= wdata;
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];
endmodule
`default_nettype wire

// File: rtl/gshare_pred.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_pred
//  Brief    : Global-history / gshare branch predictor with reset sweep and perf counters.
//  Revision : 1.0
// ============================================================================
module gshare_pred
    import riscv_pkg::*;
#(
    parameter int         HIST_BITS   = 8,
    parameter int         PHT_ENTRIES = 256,
    parameter int         MODE        = 1,
    parameter logic [1:0] INIT_STATE  = 2'b01
) (
    input wire logic    clk,
    input wire logic    rst,
    gshare_pred_if.slave bus
);
    localparam int                  IDX_BITS   = $clog2(PHT_ENTRIES);
    localparam logic [IDX_BITS-1:0] c_last_ptr = IDX_BITS'(PHT_ENTRIES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_BITS-1:0] r_ptr;
    logic [IDX_BITS-1:0] w_ptr_next;
    logic [HIST_BITS-1:0] r_hist;
    logic [31:0]         r_br_count;
    logic [31:0]         r_mispred_count;

    logic [IDX_BITS-1:0] w_hist_ext;
    logic [IDX_BITS-1:0] w_lk_idx;
    logic [1:0]          w_lk_cnt;
    logic [1:0]          w_up_cnt;
    logic                w_sweep;
    logic                w_train;
    logic                w_we;
    logic [IDX_BITS-1:0] w_waddr;
    logic [1:0]          w_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            SWEEP: begin
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == c_last_ptr)
                    w_state_next = RUN;
            end
            RUN:     w_state_next = RUN;
            default: w_state_next = SWEEP;
        endcase
    end

    assign w_sweep    = (r_state == SWEEP);
    assign w_train    = !w_sweep && bus.up_valid;
    assign w_hist_ext = IDX_BITS'(r_hist);

    generate
        if (MODE == 1) begin : g_gshare
            assign w_lk_idx = bus.lk_pc[IDX_BITS+1:2] ^ w_hist_ext;
        end else begin : g_hist_only
            assign w_lk_idx = w_hist_ext;
        end
    endgenerate

    // Sweep owns the single write port until the table is initialised.
    assign w_we    = w_sweep || w_train;
    assign w_waddr = w_sweep ? r_ptr : bus.up_idx;
    assign w_wdata = w_sweep ? INIT_STATE : sat_next(w_up_cnt, bus.up_taken);

    pht_ram #(
        .ENTRIES (PHT_ENTRIES),
        .AW      (IDX_BITS)
    ) u_pht (
        .clk     (clk),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .raddr_a (w_lk_idx),
        .rdata_a (w_lk_cnt),
        .raddr_b (bus.up_idx),
        .rdata_b (w_up_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist          <= '0;
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_train)
                r_hist <= HIST_BITS'({r_hist, bus.up_taken});
            if (bus.perf_clear) begin
                r_br_count      <= '0;
                r_mispred_count <= '0;
            end else if (w_train) begin
                r_br_count <= r_br_count + 32'd1;
                if (bus.up_mispred)
                    r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign bus.lk_idx        = w_lk_idx;
    assign bus.lk_target     = bus.lk_pc + bus.lk_imm;
    assign bus.lk_taken      = (bus.lk_opc == OPC_JAL_5) ||
                               ((bus.lk_opc == OPC_BRANCH_5) && !w_sweep && w_lk_cnt[1]);
    assign bus.ready         = !w_sweep;
    assign bus.br_count      = r_br_count;
    assign bus.mispred_count = r_mispred_count;
endmodule
`default_nettype wire
